wb_cmd_sequencer: RTL and testbench
===================================

WB_CMD_SEQUENCER -- requirements
Module: wb_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, Wishbone address width.
REQ-002 SHALL have parameter DATA_W, default 8, Wishbone data width.
REQ-003 SHALL have parameter DEPTH, default 8, command FIFO entries, power of two, at least 2.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 255, maximum cycles waiting for ack_i, at least 1.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 push_valid_i  in  1  command offered.
REQ-009 push_ready_o  out  1  FIFO not full.
REQ-010 push_addr_i / push_data_i / push_we_i / push_irq_i  in  ADDR_W / DATA_W / 1 / 1  command fields; push_irq_i means wait for irq_i after ack.
REQ-011 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-012 rsp_data_o / rsp_err_o  out  DATA_W / 1  read data (zero for writes) and timeout flag.
REQ-013 cyc_o, stb_o, we_o  out  1 each  Wishbone master controls.
REQ-014 adr_o / dat_o  out  ADDR_W / DATA_W  Wishbone address and write data.
REQ-015 dat_i / ack_i / irq_i  in  DATA_W / 1 / 1  Wishbone slave data, acknowledge and interrupt.
REQ-016 busy_o  out  1  FSM not IDLE or FIFO non-empty.
REQ-017 count_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 Push SHALL occur when push_valid_i and push_ready_o are both high; push_ready_o SHALL be low exactly when count_o equals DEPTH.
REQ-019 FIFO SHALL be in-order, with pointers wrapping modulo DEPTH; a push and a pop in the same cycle SHALL leave count_o unchanged, including when the FIFO is full.
REQ-020 FSM states SHALL be IDLE, REQ, WAIT_IRQ and RSP.
REQ-021 IDLE -> REQ when the FIFO is non-empty: pop the head; drive cyc_o, stb_o, we_o, adr_o and dat_o from the next cycle.
REQ-022 REQ: cyc_o, stb_o, adr_o, dat_o and we_o SHALL be held stable until ack_i is sampled high or the timeout is reached.
REQ-023 REQ, ack_i high: deassert cyc_o and stb_o next cycle; capture dat_i if we_o=0; go to WAIT_IRQ if the entry's irq flag is set, else RSP.
REQ-024 A timeout counter SHALL clear on entry to REQ; when it reaches ACK_TIMEOUT without ack_i, the FSM SHALL deassert cyc_o/stb_o, set rsp_err_o and go to RSP, skipping WAIT_IRQ.
REQ-025 WAIT_IRQ: go to RSP on the first cycle irq_i is high, with no timeout; an irq_i already high on entry SHALL complete on that cycle.
REQ-026 RSP: rsp_valid_o high for exactly one cycle, then IDLE; back-to-back commands therefore give at least one idle cycle between cyc_o pulses.
REQ-027 Minimum command latency, push to rsp_valid_o with zero-wait ack and no irq wait: 4 cycles.
REQ-028 ack_i sampled outside REQ SHALL be ignored.
REQ-029 rsp_data_o and rsp_err_o SHALL hold their values until the next RSP.

Reset
REQ-030 rst_i high SHALL immediately force: FSM IDLE; FIFO empty (count_o=0, push_ready_o=1); cyc_o=stb_o=we_o=0; adr_o=0, dat_o=0; rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0; busy_o=0; timeout counter 0.
REQ-031 Reset during REQ or WAIT_IRQ SHALL abort the bus cycle, with no rsp_valid_o issued for the lost command.

Structure
REQ-032 wb_cmd_pkg SHALL hold the FSM state enum and a packed command struct (addr, data, we, irq).
REQ-033 The FIFO SHALL be a separate sub-module, wb_cmd_fifo, parametrised by width and DEPTH.

Verification
REQ-034 Write addr 2, data 0x5A, irq=0, ack after 1 wait -> one cyc_o/stb_o pulse with adr_o=2, dat_o=0x5A, we_o=1; then rsp_valid_o with rsp_err_o=0 and rsp_data_o=0.
REQ-035 Read addr 1, slave returns 0xC3 -> rsp_data_o=0xC3, rsp_err_o=0.
REQ-036 Push 9 commands into DEPTH=8 while the slave withholds ack -> push_ready_o low at count_o=8; later responses come out in push order.
REQ-037 Never ack, ACK_TIMEOUT=255 -> cyc_o drops after 255 REQ cycles, rsp_err_o=1, the next command then issues.
REQ-038 Write with irq=1, irq_i raised 20 cycles after ack -> rsp_valid_o appears in the cycle after irq_i is sampled, not before.
REQ-039 rst_i pulsed mid-REQ with 3 entries queued -> all outputs at reset values, count_o=0, no rsp_valid_o.

Source files
------------

// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: sequencer FSM states and the queued command record.
package wb_cmd_pkg;
  // Fields are sized for the widest supported bus; the sequencer casts to its own widths.
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_IRQ, RSP} state_t;
  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
    logic                  we;
    logic                  irq;
  } cmd_t;
endpackage

// File: rtl/wb_cmd_fifo.sv
// wb_cmd_fifo: in-order command FIFO with occupancy count and wrapping pointers.
module wb_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem[rp];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr) mem[wp] <= din;
  end
endmodule

// File: rtl/wb_cmd_sequencer.sv
// wb_cmd_sequencer: queues Wishbone commands and runs them one at a time,
// with ack timeout and optional wait for irq_i before reporting completion.
module wb_cmd_sequencer
  import wb_cmd_pkg::*;
#(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [ADDR_W-1:0]      push_addr_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   push_we_i,
  input  logic                   push_irq_i,
  output logic                   rsp_valid_o,
  output logic [DATA_W-1:0]      rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   cyc_o,
  output logic                   stb_o,
  output logic                   we_o,
  output logic [ADDR_W-1:0]      adr_o,
  output logic [DATA_W-1:0]      dat_o,
  input  logic [DATA_W-1:0]      dat_i,
  input  logic                   ack_i,
  input  logic                   irq_i,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_n;
  cmd_t push_cmd, head_cmd;
  logic full, empty, pop, irq_q, tmo_hit;
  logic [TW-1:0] tmo;
  logic [DATA_W-1:0] cap_data, rsp_d;
  logic cap_err, rsp_e;
  assign push_cmd = '{addr: CMD_ADDR_W'(push_addr_i), data: CMD_DATA_W'(push_data_i),
                      we: push_we_i, irq: push_irq_i};
  wb_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_valid_i && push_ready_o),
    .pop   (pop),
    .din   (push_cmd),
    .dout  (head_cmd),
    .count (count_o),
    .full  (full),
    .empty (empty)
  );
  assign push_ready_o = !full;
  assign pop          = state == IDLE && !empty;
  assign busy_o       = state != IDLE || !empty;
  assign rsp_valid_o  = state == RSP;
  assign stb_o        = cyc_o;
  assign tmo_hit      = tmo == TW'(ACK_TIMEOUT - 1);
  // The result is staged in cap_* so the visible rsp_* only change on entry to RSP.
  always_comb begin
    state_n = state;
    rsp_d   = cap_data;
    rsp_e   = cap_err;
    if (pop) state_n = REQ;
    if (state == REQ && ack_i) begin
      state_n = irq_q ? WAIT_IRQ : RSP;
      rsp_d   = we_o ? '0 : dat_i;
      rsp_e   = 1'b0;
    end else if (state == REQ && tmo_hit) begin
      state_n = RSP;
      rsp_d   = '0;
      rsp_e   = 1'b1;
    end
    if (state == WAIT_IRQ && irq_i) state_n = RSP;
    if (state == RSP) state_n = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cyc_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= '0;
      dat_o      <= '0;
      irq_q      <= 1'b0;
      tmo        <= '0;
      cap_data   <= '0;
      cap_err    <= 1'b0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cap_data <= rsp_d;
      cap_err  <= rsp_e;
      tmo      <= state == REQ ? tmo + 1'b1 : '0;
      if (pop) begin
        cyc_o <= 1'b1;
        we_o  <= head_cmd.we;
        adr_o <= ADDR_W'(head_cmd.addr);
        dat_o <= DATA_W'(head_cmd.data);
        irq_q <= head_cmd.irq;
      end
      if (state == REQ && state_n != REQ) cyc_o <= 1'b0;
      if (state_n == RSP && state != RSP) begin
        rsp_data_o <= rsp_d;
        rsp_err_o  <= rsp_e;
      end
    end
  end
endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// tb_wb_cmd_sequencer: directed and random command streams against a queue-based
// model of ordered execution, a simple memory slave and bus/response monitors.
module tb_wb_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_i, push_valid_i, push_ready_o, push_we_i, push_irq_i;
  logic [1:0] push_addr_i, adr_o;
  logic [7:0] push_data_i, rsp_data_o, dat_o, dat_i;
  logic rsp_valid_o, rsp_err_o, cyc_o, stb_o, we_o, ack_i, irq_i, busy_o;
  logic [3:0] count_o;
  typedef struct {logic [1:0] a; logic [7:0] d; logic w; int len;} bus_t;
  typedef struct {logic [7:0] d; logic e;} rsp_t;
  typedef struct {logic [1:0] a; logic [7:0] d; logic w; int len; logic [7:0] rd; logic re;} exp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  exp_t exp_q[$];
  int wait_q[$];
  logic [7:0] smem [4];
  logic [7:0] shadow [4];
  int n_chk = 0, n_fail = 0, stable_err = 0, stb_err = 0, dbl_err = 0;

  wb_cmd_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_addr_i(push_addr_i), .push_data_i(push_data_i), .push_we_i(push_we_i),
    .push_irq_i(push_irq_i), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i), .busy_o(busy_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Memory slave: each bus cycle takes its ack delay from wait_q (-1 = never ack).
  initial begin
    int wcnt, cur_wait;
    bit active;
    ack_i = 1'b0; dat_i = 8'h00; active = 1'b0; wcnt = 0; cur_wait = 0;
    forever begin
      @(negedge clk);
      if (cyc_o && stb_o && !ack_i) begin
        if (!active) begin
          active = 1'b1; wcnt = 0;
          cur_wait = wait_q.size() != 0 ? wait_q.pop_front() : 0;
        end
        if (cur_wait >= 0 && wcnt == cur_wait) begin
          ack_i = 1'b1;
          dat_i = we_o ? 8'($urandom) : smem[adr_o];
          if (we_o) smem[adr_o] = dat_o;
        end else wcnt++;
      end else begin
        ack_i = 1'b0;
        if (!cyc_o) active = 1'b0;
      end
    end
  end

  initial begin
    int cyc_len;
    bit prev_rv;
    bus_t cur;
    rsp_t r;
    cyc_len = 0; prev_rv = 1'b0;
    cur = '{a: 2'd0, d: 8'd0, w: 1'b0, len: 0};
    forever begin
      @(negedge clk);
      if (rst_i) cyc_len = 0;
      else if (cyc_o) begin
        if (cyc_len == 0) begin cur.a = adr_o; cur.d = dat_o; cur.w = we_o; end
        else if (adr_o !== cur.a || dat_o !== cur.d || we_o !== cur.w) stable_err++;
        cyc_len++;
      end else if (cyc_len > 0) begin
        cur.len = cyc_len; bus_q.push_back(cur); cyc_len = 0;
      end
      if (stb_o !== cyc_o) stb_err++;
      if (rsp_valid_o === 1'b1) begin
        if (prev_rv) dbl_err++;
        r.d = rsp_data_o; r.e = rsp_err_o; rsp_q.push_back(r);
      end
      prev_rv = rsp_valid_o;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] a, input logic [7:0] d, input logic w, input logic irq, input int wt);
    exp_t e;
    int b;
    e.a = a; e.d = d; e.w = w; e.len = wt < 0 ? 255 : wt + 1;
    e.rd = (wt < 0 || w) ? 8'h00 : shadow[a];
    e.re = wt < 0;
    if (w && wt >= 0) shadow[a] = d;
    b = 0;
    while (!push_ready_o && b < 2000) begin @(negedge clk); b++; end
    chk("push_ready_wait", push_ready_o, 1);
    exp_q.push_back(e); wait_q.push_back(wt);
    push_addr_i = a; push_data_i = d; push_we_i = w; push_irq_i = irq; push_valid_i = 1'b1;
    @(negedge clk);
    push_valid_i = 1'b0;
  endtask

  task automatic expect_rsp(input string tag);
    exp_t e;
    rsp_t r;
    bus_t s;
    int b;
    b = 0;
    while (rsp_q.size() == 0 && b < 600) begin @(negedge clk); b++; end
    chk({tag, "_rsp_present"}, rsp_q.size() != 0, 1);
    chk({tag, "_bus_present"}, bus_q.size() != 0, 1);
    if (rsp_q.size() == 0 || bus_q.size() == 0 || exp_q.size() == 0) return;
    e = exp_q.pop_front(); r = rsp_q.pop_front(); s = bus_q.pop_front();
    chk({tag, "_rsp_data"}, r.d, e.rd);
    chk({tag, "_rsp_err"}, r.e, e.re);
    chk({tag, "_adr"}, s.a, e.a);
    chk({tag, "_we"}, s.w, e.w);
    if (e.w) chk({tag, "_dat"}, s.d, e.d);
    chk({tag, "_cyc_len"}, s.len, e.len);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cyc"}, cyc_o, 0);
    chk({tag, "_stb"}, stb_o, 0);
    chk({tag, "_we"}, we_o, 0);
    chk({tag, "_adr"}, adr_o, 0);
    chk({tag, "_dat"}, dat_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_data"}, rsp_data_o, 0);
    chk({tag, "_rsp_err"}, rsp_err_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_push_ready"}, push_ready_o, 1);
  endtask

  initial begin
    int n, early, nr, nb;
    rst_i = 1'b1; push_valid_i = 1'b0; push_addr_i = 2'd0; push_data_i = 8'd0;
    push_we_i = 1'b0; push_irq_i = 1'b0; irq_i = 1'b0;
    for (int i = 0; i < 4; i++) begin smem[i] = 8'($urandom); shadow[i] = smem[i]; end
    smem[1] = 8'hC3; shadow[1] = 8'hC3;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk);

    send(2'd2, 8'h5A, 1'b1, 1'b0, 1);
    expect_rsp("write_5a");

    send(2'd1, 8'h00, 1'b0, 1'b0, 0);
    n = 0;
    while (!rsp_valid_o && n < 20) begin @(negedge clk); n++; end
    chk("latency_cycles", n + 2, 4);
    chk("read_c3_direct", rsp_data_o, 8'hC3);
    expect_rsp("read_c3");

    irq_i = 1'b1;
    send(2'd3, 8'h00, 1'b0, 1'b1, 0);
    n = 0;
    while (!rsp_valid_o && n < 20) begin @(negedge clk); n++; end
    chk("irq_preset_latency", n + 2, 5);
    irq_i = 1'b0;
    expect_rsp("irq_preset");

    send(2'd0, 8'hA6, 1'b1, 1'b1, 0);
    n = 0;
    while (!cyc_o && n < 20) begin @(negedge clk); n++; end
    while (cyc_o && n < 40) begin @(negedge clk); n++; end
    chk("irq_cyc_done", cyc_o, 0);
    early = 0;
    repeat (19) begin
      if (rsp_valid_o) early++;
      @(negedge clk);
    end
    chk("irq_busy_waiting", busy_o, 1);
    chk("irq_no_early_rsp", early + rsp_valid_o, 0);
    irq_i = 1'b1;
    @(negedge clk);
    chk("irq_rsp_after_irq", rsp_valid_o, 1);
    irq_i = 1'b0;
    expect_rsp("irq_wait");

    send(2'($urandom), 8'($urandom), 1'b0, 1'b0, 40);
    for (int i = 0; i < 8; i++) send(2'(i), 8'($urandom), 1'(i % 2), 1'b0, 0);
    chk("full_count", count_o, 8);
    chk("full_ready", push_ready_o, 0);
    push_addr_i = 2'd1; push_data_i = 8'hEE; push_we_i = 1'b1; push_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    push_valid_i = 1'b0;
    chk("full_hold_count", count_o, 8);
    send(2'd3, 8'h3C, 1'b1, 1'b0, 2);
    for (int i = 0; i < 10; i++) expect_rsp("fifo_order");

    send(2'd0, 8'h11, 1'b1, 1'b0, -1);
    send(2'd3, 8'h22, 1'b1, 1'b0, 0);
    expect_rsp("timeout");
    expect_rsp("after_timeout");

    for (int i = 0; i < 30; i++) begin
      send(2'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 30; i++) expect_rsp("random");

    send(2'd1, 8'h00, 1'b0, 1'b0, 60);
    for (int i = 0; i < 3; i++) send(2'(i), 8'h00, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("mid_req_count", count_o, 3);
    chk("mid_req_cyc", cyc_o, 1);
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete(); wait_q.delete();
    nr = rsp_q.size(); nb = bus_q.size();
    repeat (20) @(negedge clk);
    chk("reset_no_rsp", rsp_q.size(), nr);
    chk("reset_no_bus", bus_q.size(), nb);
    chk("reset_idle_count", count_o, 0);
    send(2'd2, 8'h77, 1'b1, 1'b0, 0);
    expect_rsp("post_reset");

    chk("bus_stable", stable_err, 0);
    chk("stb_eq_cyc", stb_err, 0);
    chk("rsp_single_pulse", dbl_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
